cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/breakpoint sequencer and IO-bus slave for the single-cycle CPU.
//  Drives the CPU clock-enable (cpu_en) from host run/step controls with one PC breakpoint.
//  Also decodes the CPU IO bus (io_addr/io_dout/io_we/io_din) into LED, input and output handshake registers.
//  Sits between the CPU core and the board/host debug unit.
// PARAMETERS
//  LED_W  16  width of LED output register (io_dout[LED_W-1:0] captured)
//  CNT_W  32  width of executed-cycle counter (zero-extended to 32 on io_din)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-low reset (0 = reset)
//  run       in   1      level: 1 = free-run request
//  step      in   1      level from debounced button; rising edge = one-instruction step
//  brk_en    in   1      breakpoint enable
//  brk_pc    in   32     breakpoint address
//  pc        in   32     current CPU PC
//  cpu_en    out  1      CPU clock-enable (PC/RF/mem update only when 1)
//  halted    out  1      1 in HALT or BREAK state
//  brk_hit   out  1      1 in BREAK state
//  io_addr   in   8      CPU IO address
//  io_dout   in   32     CPU IO write data
//  io_we     in   1      CPU IO write strobe
//  io_din    out  32     CPU IO read data (combinational on io_addr)
//  in_vld    in   1      host input valid pulse, 1 cycle
//  in_data   in   32     host input data
//  out_vld   out  1      output word pending for host
//  out_data  out  32     output word
//  out_ack   in   1      host consumed output word
//  led       out  LED_W  LED register
// BEHAVIOUR
//  Reset (rst=0, async): state=HALT, led=0, out_vld=0, out_data=0, in buffer empty/0,
//   cycle counter=0, step edge register=0, first=0; hence cpu_en=0, halted=1, brk_hit=0.
//  step_rise = step & ~step_q (step_q is step registered).
//  FSM (registered state; cpu_en combinational from state and pc):
//   HALT : run=1 -> RUN (set first=1); else step_rise -> STEP; else stay. cpu_en=0.
//   RUN  : hit = brk_en & (pc==brk_pc) & ~first. cpu_en = ~hit.
//          hit -> BREAK; else run=0 -> HALT; else stay. first cleared after each RUN cycle.
//   STEP : cpu_en=1 exactly one cycle -> HALT.
//   BREAK: cpu_en=0. run=0 -> HALT; step_rise -> STEP; run=1 & no step -> stay.
//  first lets RUN entered at pc==brk_pc leave the breakpoint without re-triggering.
//  In HALT, run=1 and step_rise together: run wins.
//  IO writes commit only when io_we & cpu_en (no side effects while stalled).
//  IO map (io_addr):
//   0x00 W  led <= io_dout[LED_W-1:0];  R led zero-extended.
//   0x04 R  {31'b0, in_full}.
//   0x08 R  in_buf; read with cpu_en=1 clears in_full.
//   0x0C R  {31'b0, ~out_vld}.
//   0x10 W  out_data <= io_dout, out_vld <= 1;  R out_data.
//   0x14 R  executed-cycle counter, zero-extended.
//   Other addresses: reads 0, writes ignored.
//  Input buffer: in_vld loads in_buf and sets in_full. in_vld and a consuming 0x08 read
//   in the same cycle: new data loaded, in_full stays 1. in_vld while full overwrites.
//  Output: out_ack clears out_vld. 0x10 write and out_ack in the same cycle: new data, out_vld=1.
//  Counter increments each cycle cpu_en=1 and wraps at 2^CNT_W-1 -> 0.
//  io_din has zero latency (combinational mux); all register updates take effect on the next clk edge.
// TESTING
//  1 Reset mid-RUN: rst=0 asynchronously -> cpu_en=0 and halted=1 immediately; led=0, counter=0.
//  2 HALT, three step rising edges, step held high 5 cycles each -> exactly 3 cpu_en=1 cycles; counter=3.
//  3 brk_en=1, brk_pc=0x0C, run=1 with pc advancing by 4 from 0 -> cpu_en=0 in the cycle pc==0x0C,
//    then brk_hit=1; run=0 then run=1 -> pc leaves 0x0C; cpu_en stays 1 in that first RUN cycle.
//  4 RUN, CPU writes 0x10 data 0xA5 -> out_vld=1, out_data=0xA5; out_ack with a second write
//    0x5A in the same cycle -> out_vld=1, out_data=0x5A.
//  5 in_vld with 0x1234 -> addr 0x04 reads 1; CPU read of 0x08 with cpu_en=1 returns 0x1234, then 0x04
//    reads 0; same 0x08 read while halted leaves in_full=1.
//  6 Counter preloaded near max (CNT_W=4 build) -> wraps 15 -> 0 on the next enabled cycle.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// IO bus and host handshake bundle between the CPU core / host and cpu_run_ctrl.
// The master modport is the CPU/host side; the slave modport is the controller.
interface cpu_run_ctrl_if;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic [31:0] io_din;
    logic        in_vld;
    logic [31:0] in_data;
    logic        out_vld;
    logic [31:0] out_data;
    logic        out_ack;

    modport master (
        output io_addr, io_dout, io_we, in_vld, in_data, out_ack,
        input  io_din, out_vld, out_data
    );

    modport slave (
        input  io_addr, io_dout, io_we, in_vld, in_data, out_ack,
        output io_din, out_vld, out_data
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer producing the CPU clock-enable, plus the IO-bus
// slave holding LED, host input buffer, host output word and executed-cycle counter.
module cpu_run_ctrl #(
    parameter int unsigned LED_W = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               brk_en,
    input  logic [31:0]        brk_pc,
    input  logic [31:0]        pc,
    output logic               cpu_en,
    output logic               halted,
    output logic               brk_hit,
    cpu_run_ctrl_if.slave      bus,
    output logic [LED_W-1:0]   led
);
    typedef enum logic [1:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_BREAK
    } state_t;

    state_t           state;
    logic             first;
    logic             step_q;
    logic             step_rise;
    logic             hit;
    logic             wr_en;
    logic             in_full;
    logic [31:0]      in_buf;
    logic [CNT_W-1:0] cnt;

    assign step_rise = step & ~step_q;
    // first suppresses the match on the cycle RUN is entered, so a resume at brk_pc proceeds
    assign hit       = (state == S_RUN) & brk_en & (pc == brk_pc) & ~first;
    assign wr_en     = bus.io_we & cpu_en;

    always_comb begin
        case (state)
            S_RUN:   cpu_en = ~hit;
            S_STEP:  cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            brk_hit <= 1'b0;
            first   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            case (state)
                S_HALT: begin
                    if (run) begin
                        state  <= S_RUN;
                        first  <= 1'b1;
                        halted <= 1'b0;
                    end else if (step_rise) begin
                        state  <= S_STEP;
                        halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    first <= 1'b0;
                    if (hit) begin
                        state   <= S_BREAK;
                        halted  <= 1'b1;
                        brk_hit <= 1'b1;
                    end else if (!run) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_STEP: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
                S_BREAK: begin
                    if (!run) begin
                        state   <= S_HALT;
                        brk_hit <= 1'b0;
                    end else if (step_rise) begin
                        state   <= S_STEP;
                        halted  <= 1'b0;
                        brk_hit <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_HALT;
                    halted  <= 1'b1;
                    brk_hit <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led          <= '0;
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            in_buf       <= '0;
            in_full      <= 1'b0;
            cnt          <= '0;
        end else begin
            if (wr_en && bus.io_addr == 8'h00) led <= bus.io_dout[LED_W-1:0];
            // a new output write beats a simultaneous host acknowledge
            if (wr_en && bus.io_addr == 8'h10) begin
                bus.out_data <= bus.io_dout;
                bus.out_vld  <= 1'b1;
            end else if (bus.out_ack) begin
                bus.out_vld <= 1'b0;
            end
            if (bus.in_vld) begin
                in_buf  <= bus.in_data;
                in_full <= 1'b1;
            end else if (cpu_en && bus.io_addr == 8'h08) begin
                in_full <= 1'b0;
            end
            if (cpu_en) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        case (bus.io_addr)
            8'h00:   bus.io_din = 32'(led);
            8'h04:   bus.io_din = {31'b0, in_full};
            8'h08:   bus.io_din = in_buf;
            8'h0C:   bus.io_din = {31'b0, ~bus.out_vld};
            8'h10:   bus.io_din = bus.out_data;
            8'h14:   bus.io_din = 32'(cnt);
            default: bus.io_din = '0;
        endcase
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: the stimulus side predicts every cycle's outputs
// from a behavioural model and queues them; a negedge monitor compares against the DUT.
module tb_cpu_run_ctrl;
    localparam int unsigned LED_W = 16;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic        cpu_en;
        logic        halted;
        logic        brk_hit;
        logic        out_vld;
        logic [31:0] io_din;
        logic [31:0] out_data;
        logic [31:0] led;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             step;
    logic             brk_en;
    logic [31:0]      brk_pc;
    logic [31:0]      pc;
    logic             cpu_en;
    logic             halted;
    logic             brk_hit;
    logic [LED_W-1:0] led;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(.LED_W(LED_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .step    (step),
        .brk_en  (brk_en),
        .brk_pc  (brk_pc),
        .pc      (pc),
        .cpu_en  (cpu_en),
        .halted  (halted),
        .brk_hit (brk_hit),
        .bus     (bus),
        .led     (led)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // reference model: activity flags rather than a state number
    bit          m_running, m_stepping, m_broken, m_first, m_stepq;
    bit          m_outv, m_inf;
    int unsigned m_led, m_outd, m_inb, m_cnt;
    logic [31:0] pc_nxt;
    logic [31:0] pc_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_running = 0; m_stepping = 0; m_broken = 0; m_first = 0; m_stepq = 0;
        m_outv = 0; m_inf = 0; m_led = 0; m_outd = 0; m_inb = 0; m_cnt = 0;
        pc_nxt = pc;
    endtask

    task automatic drive(input bit r, input bit s, input logic [7:0] a, input logic [31:0] d,
                         input bit we, input bit iv, input logic [31:0] idat, input bit ack);
        exp_t e;
        bit   rise, hit, en;
        run = r; step = s;
        bus.io_addr = a; bus.io_dout = d; bus.io_we = we;
        bus.in_vld = iv; bus.in_data = idat; bus.out_ack = ack;
        rise = s && !m_stepq;
        hit  = m_running && brk_en && (pc == brk_pc) && !m_first;
        en   = m_stepping || (m_running && !hit);
        e.cpu_en   = en;
        e.halted   = !(m_running || m_stepping);
        e.brk_hit  = m_broken;
        e.out_vld  = m_outv;
        e.out_data = m_outd;
        e.led      = m_led;
        case (a)
            8'h00:   e.io_din = m_led;
            8'h04:   e.io_din = {31'b0, m_inf};
            8'h08:   e.io_din = m_inb;
            8'h0C:   e.io_din = {31'b0, !m_outv};
            8'h10:   e.io_din = m_outd;
            8'h14:   e.io_din = m_cnt;
            default: e.io_din = 0;
        endcase
        sb.push_back(e);
        if (m_stepping) begin
            m_stepping = 0;
        end else if (m_running) begin
            m_first = 0;
            if (hit) begin m_running = 0; m_broken = 1; end
            else if (!r) m_running = 0;
        end else if (m_broken) begin
            if (!r) m_broken = 0;
            else if (rise) begin m_broken = 0; m_stepping = 1; end
        end else if (r) begin
            m_running = 1; m_first = 1;
        end else if (rise) begin
            m_stepping = 1;
        end
        if (we && en && a == 8'h00) m_led = d & ((1 << LED_W) - 1);
        if (ack) m_outv = 0;
        if (we && en && a == 8'h10) begin m_outd = d; m_outv = 1; end
        if (en && a == 8'h08) m_inf = 0;
        if (iv) begin m_inb = idat; m_inf = 1; end
        if (en) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_stepq = s;
        pc_nxt = en ? ((pc + 32'd4) & pc_mask) : pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pc = pc_nxt;
    endtask

    task automatic cyc(input bit r, input bit s, input logic [7:0] a);
        drive(r, s, a, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cpu_en",   {31'b0, cpu_en},      {31'b0, e.cpu_en});
                chk("halted",   {31'b0, halted},      {31'b0, e.halted});
                chk("brk_hit",  {31'b0, brk_hit},     {31'b0, e.brk_hit});
                chk("out_vld",  {31'b0, bus.out_vld}, {31'b0, e.out_vld});
                chk("out_data", bus.out_data,         e.out_data);
                chk("led",      32'(led),             e.led);
                chk("io_din",   bus.io_din,           e.io_din);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [7:0] addrs [7];
        bit         r, s;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20};
        rst = 1'b0; run = 0; step = 0; brk_en = 0; brk_pc = 0; pc = 0; pc_mask = 32'hFF;
        bus.io_addr = 0; bus.io_dout = 0; bus.io_we = 0;
        bus.in_vld = 0; bus.in_data = 0; bus.out_ack = 0;
        m_reset();
        @(posedge clk); #1;
        bus.io_addr = 8'h14; #1;
        chk("rst_cpu_en",  {31'b0, cpu_en},      32'd0);
        chk("rst_halted",  {31'b0, halted},      32'd1);
        chk("rst_brk_hit", {31'b0, brk_hit},     32'd0);
        chk("rst_out_vld", {31'b0, bus.out_vld}, 32'd0);
        chk("rst_cnt",     bus.io_din,           32'd0);
        bus.io_addr = 8'h04; #1;
        chk("rst_in_full", bus.io_din,           32'd0);
        rst = 1'b1;
        tick();

        // three step presses, each held five cycles
        for (int k = 0; k < 3; k++) begin
            repeat (5) cyc(0, 1, 8'h14);
            repeat (3) cyc(0, 0, 8'h14);
        end
        drive(0, 0, 8'h14, 0, 0, 0, 0, 0); #1;
        chk("step_count", bus.io_din, 32'd3);
        tick();

        // breakpoint at 0x0C, then resume from it
        pc = 0; pc_nxt = 0; brk_en = 1; brk_pc = 32'h0C;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 8'h14, 0, 0, 0, 0, 0);
            if (pc == 32'h0C) begin
                #1 chk("brk_cycle_en", {31'b0, cpu_en}, 32'd0);
                tick();
                break;
            end
            tick();
        end
        drive(1, 0, 8'h14, 0, 0, 0, 0, 0); #1;
        chk("brk_hit_set", {31'b0, brk_hit}, 32'd1);
        tick();
        cyc(0, 0, 8'h14);
        cyc(1, 0, 8'h14);
        drive(1, 0, 8'h14, 0, 0, 0, 0, 0); #1;
        chk("resume_en", {31'b0, cpu_en}, 32'd1);
        tick();
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        brk_en = 0;

        // output handshake; the HALT-cycle write must be ignored
        drive(1, 0, 8'h10, 32'h77, 1, 0, 0, 0); tick();
        drive(1, 0, 8'h10, 32'hA5, 1, 0, 0, 0); tick();
        drive(1, 0, 8'h10, 32'h5A, 1, 0, 0, 1); #1;
        chk("out_data_a5", bus.out_data, 32'hA5);
        tick();
        drive(1, 0, 8'h0C, 0, 0, 0, 0, 1); #1;
        chk("out_data_5a", bus.out_data, 32'h5A);
        chk("out_vld_5a",  {31'b0, bus.out_vld}, 32'd1);
        tick();
        drive(0, 0, 8'h0C, 0, 0, 0, 0, 0); #1;
        chk("out_vld_ack", {31'b0, bus.out_vld}, 32'd0);
        tick();

        // input buffer: read while halted keeps it full, enabled read drains it
        drive(0, 0, 8'h04, 0, 0, 1, 32'h1234, 0); tick();
        drive(0, 0, 8'h04, 0, 0, 0, 0, 0); #1 chk("in_full_set", bus.io_din, 32'd1); tick();
        drive(0, 0, 8'h08, 0, 0, 0, 0, 0); #1 chk("in_rd_halt", bus.io_din, 32'h1234); tick();
        drive(0, 0, 8'h04, 0, 0, 0, 0, 0); #1 chk("in_full_kept", bus.io_din, 32'd1); tick();
        cyc(1, 0, 8'h04);
        drive(1, 0, 8'h08, 0, 0, 0, 0, 0); #1 chk("in_rd_run", bus.io_din, 32'h1234); tick();
        drive(1, 0, 8'h04, 0, 0, 0, 0, 0); #1 chk("in_full_clr", bus.io_din, 32'd0); tick();

        // counter wrap
        for (int i = 0; i < 40 && !(m_cnt == 15 && m_running); i++) cyc(1, 0, 8'h14);
        drive(1, 0, 8'h14, 0, 0, 0, 0, 0); #1 chk("cnt_max", bus.io_din, 32'd15); tick();
        drive(1, 0, 8'h14, 0, 0, 0, 0, 0); #1 chk("cnt_wrap", bus.io_din, 32'd0); tick();

        // asynchronous reset while running
        drive(1, 0, 8'h00, 32'hBEEF, 1, 0, 0, 0); tick();
        drive(1, 0, 8'h14, 0, 0, 0, 0, 0);
        #6;
        chk("pre_rst_en", {31'b0, cpu_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_en",     {31'b0, cpu_en}, 32'd0);
        chk("mid_rst_halted", {31'b0, halted}, 32'd1);
        chk("mid_rst_led",    32'(led),        32'd0);
        chk("mid_rst_cnt",    bus.io_din,      32'd0);
        run = 0;
        pc = 0;
        m_reset();
        tick();
        rst = 1'b1;
        tick();

        // randomized phase
        pc_mask = 32'h3F; r = 0; s = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) r = !r;
            if ($urandom_range(0, 4) == 0) s = !s;
            if ($urandom_range(0, 49) == 0) brk_en = !brk_en;
            if ($urandom_range(0, 29) == 0) brk_pc = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 31) == 0) begin
                pc = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            end
            drive(r, s, addrs[$urandom_range(0, 6)], $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) == 0);
            tick();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
